eab_agu: RTL

- Sequential, parametrised successor to the LC-3 effective-address adder.
- Computes base (PC or Ra) + sign-extended IR offset, then emits BURST consecutive addresses on a valid/ready stream.
- Sits between decode/control and the memory address path; serves LD/ST/LDR/JSR-style single addresses and multi-word transfers.
- One request is in flight at a time. A new request may be accepted on the same cycle the last beat is consumed.

---
 rtl/eab_agu_if.sv | 36 +++
 rtl/eab_agu.sv | 116 +++++++++++
 2 files changed

// File: rtl/eab_agu_if.sv
`default_nettype none
// ============================================================================
// Module      : eab_agu_if
// Description : Request/beat stream bundle for the effective-address AGU.
// Revision    : 1.0 - initial release
// ============================================================================
interface eab_agu_if #(
    parameter int WIDTH   = 16,
    parameter int IR_W    = 11,
    parameter int BURST_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [IR_W-1:0]    ir;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   pc;
    logic               sel_base;
    logic [1:0]         sel_off;
    logic [BURST_W-1:0] burst_len;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   ea;
    logic               out_last;
    logic               out_wrap;

    modport master (
        output in_valid, ir, ra, pc, sel_base, sel_off, burst_len, out_ready,
        input  in_ready, out_valid, ea, out_last, out_wrap
    );

    modport slave (
        input  in_valid, ir, ra, pc, sel_base, sel_off, burst_len, out_ready,
        output in_ready, out_valid, ea, out_last, out_wrap
    );
endinterface
`default_nettype wire

// File: rtl/eab_agu.sv
`default_nettype none
// ============================================================================
// Module      : eab_agu
// Description : Base + sign-extended IR offset, streamed as a burst of
//               consecutive addresses on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module eab_agu #(
    parameter int WIDTH   = 16,
    parameter int IR_W    = 11,
    parameter int BURST_W = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    eab_agu_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    localparam logic [BURST_W-1:0] c_one = BURST_W'(1);

    logic [0:0]         r_state;
    logic [0:0]         w_stateNext;
    logic [WIDTH-1:0]   r_ea;
    logic [BURST_W-1:0] r_remaining;
    logic               r_wrap;

    logic               w_inReady;
    logic               w_outValid;
    logic               w_isLast;
    logic               w_accept;
    logic               w_consume;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_offset;
    logic [WIDTH-1:0]   w_sum;
    logic [BURST_W-1:0] w_beats;

    // Only ir[10:0] participates; the three offset fields overlap in it.
    always_comb begin
        w_offset = '0;
        case (bus.sel_off)
            2'b00:   w_offset = '0;
            2'b01:   w_offset = {{(WIDTH-11){bus.ir[10]}}, bus.ir[10:0]};
            2'b10:   w_offset = {{(WIDTH-9){bus.ir[8]}}, bus.ir[8:0]};
            default: w_offset = {{(WIDTH-6){bus.ir[5]}}, bus.ir[5:0]};
        endcase
    end

    assign w_base  = bus.sel_base ? bus.ra : bus.pc;
    assign w_sum   = w_base + w_offset;
    assign w_beats = (bus.burst_len == '0) ? c_one : bus.burst_len;

    assign w_isLast  = (r_remaining == c_one);
    assign w_accept  = bus.in_valid && w_inReady;
    assign w_consume = w_outValid && bus.out_ready;

    always_comb begin
        w_stateNext = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_inReady = !rst;
                if (w_accept) begin
                    w_stateNext = S_EMIT;
                end
            end
            default: begin
                w_outValid = 1'b1;
                // Last-beat handoff lets a new request start with no bubble.
                w_inReady  = !rst && bus.out_ready && w_isLast;
                if (w_consume && w_isLast) begin
                    w_stateNext = w_accept ? S_EMIT : S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ea        <= '0;
            r_remaining <= '0;
            r_wrap      <= 1'b0;
        end else if (w_accept) begin
            r_ea        <= w_sum;
            r_remaining <= w_beats;
            r_wrap      <= 1'b0;
        end else if (w_consume) begin
            if (w_isLast) begin
                r_remaining <= '0;
            end else begin
                r_ea        <= r_ea + WIDTH'(1);
                r_remaining <= r_remaining - c_one;
                if (r_ea == {WIDTH{1'b1}}) begin
                    r_wrap <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.ea        = r_ea;
    assign bus.out_last  = w_isLast;
    assign bus.out_wrap  = r_wrap;

endmodule
`default_nettype wire
